// File: rtl/timing_sync_gen.sv
// Display timing generator: free-running h/v counters, programmable sync/porch/active
// windows with per-signal polarity, and config shadows that swap only at frame boundaries.
module timing_sync_gen #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          i_resetn,
    input  logic          i_en,
    input  logic          i_cfg_upd,
    input  logic [CW-1:0] i_htot,
    input  logic [CW-1:0] i_hsw,
    input  logic [CW-1:0] i_hbp,
    input  logic [CW-1:0] i_hact,
    input  logic [CW-1:0] i_vtot,
    input  logic [CW-1:0] i_vsw,
    input  logic [CW-1:0] i_vbp,
    input  logic [CW-1:0] i_vact,
    input  logic          i_hs_pol,
    input  logic          i_vs_pol,
    input  logic          i_de_pol,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          o_frame_start,
    output logic          o_line_start,
    output logic [CW-1:0] o_hcnt,
    output logic [CW-1:0] o_vcnt,
    output logic          o_cfg_err
);

    localparam int SW = CW + 2;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q;
    logic [CW-1:0] hcnt_q, vcnt_q;
    logic [CW-1:0] htot_q, hsw_q, hbp_q, hact_q;
    logic [CW-1:0] vtot_q, vsw_q, vbp_q, vact_q;
    logic          hs_pol_q, vs_pol_q, de_pol_q;
    logic          pend_q;
    logic          hsync_q, vsync_q, de_q, frame_start_q, line_start_q, cfg_err_q;
    logic [CW-1:0] hcnt_out_q, vcnt_out_q;

    function automatic logic [SW-1:0] ext(input logic [CW-1:0] v);
        return {2'b00, v};
    endfunction

    // Window edges are computed two bits wider so large porches never wrap into range.
    logic [SW-1:0] h_de_lo, h_de_hi, v_de_lo, v_de_hi;
    logic          running, hs_act, vs_act, de_act;
    logic          line_end, frame_end, load_now, cfg_bad;

    assign h_de_lo = ext(hsw_q) + ext(hbp_q);
    assign h_de_hi = h_de_lo + ext(hact_q);
    assign v_de_lo = ext(vsw_q) + ext(vbp_q);
    assign v_de_hi = v_de_lo + ext(vact_q);

    assign running = (state_q == RUN);
    assign hs_act  = running && (hcnt_q < hsw_q);
    assign vs_act  = running && (vcnt_q < vsw_q);
    assign de_act  = running &&
                     (ext(hcnt_q) >= h_de_lo) && (ext(hcnt_q) < h_de_hi) &&
                     (ext(vcnt_q) >= v_de_lo) && (ext(vcnt_q) < v_de_hi);

    assign line_end  = (hcnt_q == htot_q);
    assign frame_end = running && line_end && (vcnt_q == vtot_q);

    // A request arriving on the frame-end cycle itself is honoured immediately.
    assign load_now = ((state_q == IDLE) && i_en) ||
                      (frame_end && (pend_q || i_cfg_upd));

    assign cfg_bad = (ext(i_hsw) + ext(i_hbp) + ext(i_hact) > ext(i_htot) + SW'(1)) ||
                     (ext(i_vsw) + ext(i_vbp) + ext(i_vact) > ext(i_vtot) + SW'(1)) ||
                     (i_hsw == '0) || (i_vsw == '0);

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q       <= IDLE;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            htot_q        <= '0;
            hsw_q         <= '0;
            hbp_q         <= '0;
            hact_q        <= '0;
            vtot_q        <= '0;
            vsw_q         <= '0;
            vbp_q         <= '0;
            vact_q        <= '0;
            hs_pol_q      <= 1'b0;
            vs_pol_q      <= 1'b0;
            de_pol_q      <= 1'b0;
            pend_q        <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            hcnt_out_q    <= '0;
            vcnt_out_q    <= '0;
        end else begin
            hsync_q       <= hs_act ~^ hs_pol_q;
            vsync_q       <= vs_act ~^ vs_pol_q;
            de_q          <= de_act ~^ de_pol_q;
            frame_start_q <= running && (hcnt_q == '0) && (vcnt_q == '0);
            line_start_q  <= running && (hcnt_q == '0);
            hcnt_out_q    <= hcnt_q;
            vcnt_out_q    <= vcnt_q;

            pend_q <= load_now ? 1'b0 : (pend_q | i_cfg_upd);

            if (load_now) begin
                htot_q    <= i_htot;
                hsw_q     <= i_hsw;
                hbp_q     <= i_hbp;
                hact_q    <= i_hact;
                vtot_q    <= i_vtot;
                vsw_q     <= i_vsw;
                vbp_q     <= i_vbp;
                vact_q    <= i_vact;
                hs_pol_q  <= i_hs_pol;
                vs_pol_q  <= i_vs_pol;
                de_pol_q  <= i_de_pol;
                cfg_err_q <= cfg_bad;
            end

            case (state_q)
                IDLE: begin
                    hcnt_q <= '0;
                    vcnt_q <= '0;
                    if (i_en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (line_end) begin
                        hcnt_q <= '0;
                        if (vcnt_q == vtot_q) begin
                            vcnt_q <= '0;
                            if (!i_en) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            vcnt_q <= vcnt_q + CW'(1);
                        end
                    end else begin
                        hcnt_q <= hcnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hcnt_q  <= '0;
                    vcnt_q  <= '0;
                end
            endcase
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_frame_start = frame_start_q;
    assign o_line_start  = line_start_q;
    assign o_hcnt        = hcnt_out_q;
    assign o_vcnt        = vcnt_out_q;
    assign o_cfg_err     = cfg_err_q;

endmodule

// File: doc/timing_sync_gen.md
Name: timing_sync_gen

Overview:
- Parametrised next-generation display timing generator; replaces externally driven h/v counters with internal free-running counters.
- Produces hsync, vsync and DE with programmable porches and per-signal polarity, plus frame/line markers.
- Timing config is shadowed and applied only at frame boundaries.
- Sits between the line-control block and the output pads; drives the downstream panel interface.

Parameters:
CW, 12, width of counters and all timing fields (max line/frame length 2^CW)

Ports:
clk  in  1  pixel clock
i_resetn  in  1  asynchronous active-low reset
i_en  in  1  run enable; level sensitive
i_cfg_upd  in  1  1-cycle request to load new timing at next frame boundary
i_htot  in  CW  clocks per line minus 1
i_hsw  in  CW  hsync width, clocks
i_hbp  in  CW  horizontal back porch, clocks
i_hact  in  CW  active pixels per line
i_vtot  in  CW  lines per frame minus 1
i_vsw  in  CW  vsync width, lines
i_vbp  in  CW  vertical back porch, lines
i_vact  in  CW  active lines per frame
i_hs_pol, i_vs_pol, i_de_pol  in  1 each  1 = active-high, 0 = active-low (sampled into shadow)
o_hsync, o_vsync, o_de  out  1 each  timing outputs, polarity applied
o_frame_start  out  1  1-cycle pulse on first clock of each frame
o_line_start  out  1  1-cycle pulse on first clock of each line
o_hcnt, o_vcnt  out  CW each  counter values aligned with outputs
o_cfg_err  out  1  shadow config inconsistent

Behaviour:
- Reset (async): state = IDLE; counters, shadows, pending flag and all outputs = 0 (outputs 0 regardless of polarity).
- FSM IDLE:
  - Counters held at 0.
  - Outputs at inactive level (~pol of current shadow; shadow pol = 0 after reset, so outputs = 1 from the first non-reset cycle until a config is loaded).
  - i_en=1 -> load all shadows from inputs, clear pending, go RUN, hcnt=vcnt=0.
- FSM RUN:
  - hcnt increments each clock; when hcnt==htot, hcnt wraps to 0 and vcnt increments.
  - When hcnt==htot and vcnt==vtot (frame end):
    - vcnt wraps to 0.
    - If pending, shadows load and pending clears.
    - If i_en=0, go IDLE.
- i_en deassert mid-frame: current frame completes in full, then IDLE. Re-assert before frame end: no interruption.
- i_cfg_upd sets sticky pending in any state. Multiple requests within a frame collapse to one load, using input values sampled at the frame-end cycle. Request in the same cycle as frame end: loaded immediately.
- Window decode (combinational on internal counters, shadow values):
  - hs_act = hcnt < hsw
  - vs_act = vcnt < vsw
  - de_act = hcnt in [hsw+hbp, hsw+hbp+hact) AND vcnt in [vsw+vbp, vsw+vbp+vact)
  - All sums evaluated at CW+2 bits; no wrap.
- Outputs registered: output = act XNOR pol. Latency 1 clock from counter to output. o_hcnt/o_vcnt are the 1-cycle-delayed counters, so they are aligned with the outputs.
- o_frame_start = 1 on the output cycle with o_hcnt=0, o_vcnt=0 in RUN. o_line_start = 1 whenever o_hcnt=0 in RUN.
- o_cfg_err: registered at each shadow load. Set if hsw+hbp+hact > htot+1, or vsw+vbp+vact > vtot+1, or hsw=0, or vsw=0. Outputs still generated; DE is naturally clipped at the line/frame end.
- Zero-width fields: hact=0 or vact=0 gives DE never active; no error.

Test Plan:
- Basic timing: htot=15, hsw=2, hbp=3, hact=8, vtot=9, vsw=1, vbp=2, vact=5, all pol=1, i_en=1 -> frame = 160 clocks; o_hsync high at o_hcnt 0-1; o_de high at o_hcnt 5-12 on o_vcnt 3-7 (40 DE cycles per frame); o_vsync high for o_vcnt=0; o_frame_start every 160 clocks; o_cfg_err=0.
- Polarity: same timing with all pol=0 -> every output is the exact complement of the basic case; IDLE level = 1.
- Config update: pulse i_cfg_upd with hact=6 at o_vcnt=4 -> current frame keeps 8-clock DE; the next frame starts with 6-clock DE at o_hcnt 5-10.
- Graceful stop: drop i_en at o_vcnt=2 -> frame runs to count 159, then IDLE (counters 0, outputs inactive); no further o_frame_start.
- Reset mid-frame: assert i_resetn=0 at o_hcnt=7, o_vcnt=4 -> all outputs 0 in the same cycle without a clock edge; after release with i_en=1, a new frame starts from 0.
- Config error: hact=12 with htot=15 -> o_cfg_err=1 after load; DE high at o_hcnt 5-15 (11 clocks, clipped), with no DE spill into the next line.
